// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Conditions four raw push-button levels for a game FSM. Each button is
// brought into the clock domain by a two-stage synchronizer. A press is
// accepted only after DEBOUNCE_CICLOS consecutive identical samples, and a
// release only after a run of zero samples. A filtered press produces at most
// one outcome:
//   - one-hot pattern with habilita=1 -> jogada_feita pulse and jogada updated
//   - two or more buttons             -> invalida pulse
//   - one-hot pattern with habilita=0 -> silently discarded
//
// Parameters
//   DEBOUNCE_CICLOS : stable samples required (2..65535), default 500
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   botoes[3:0]  : raw asynchronous button levels, 1 = pressed
//   habilita     : downstream FSM accepts a move (sampled on the decision edge)
//   jogada[3:0]  : one-hot code of the last accepted move (held)
//   jogada_feita : single-cycle pulse, move accepted
//   invalida     : single-cycle pulse, multi-button press rejected
//   tem_jogada   : high while a debounced nonzero pattern is held
//   db_estado    : current FSM state code for debug display
// -----------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int unsigned DEBOUNCE_CICLOS = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       invalida,
    output logic       tem_jogada,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        FILTRANDO     = 3'd1,
        ACEITA        = 3'd2,
        REJEITA       = 3'd3,
        ESPERA_SOLTAR = 3'd4,
        FILTRA_SOLTAR = 3'd5
    } estado_t;

    // Counter value at which the stability run is complete.
    localparam logic [15:0] ALVO = 16'(DEBOUNCE_CICLOS - 1);

    estado_t     estado;
    logic [3:0]  sinc_p0;
    logic [3:0]  sinc;
    logic [3:0]  capturado;
    logic [15:0] contador;

    // Exactly one bit set.
    function automatic logic um_quente(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Two or more bits set.
    function automatic logic multiplos(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    // Saturating increment: the counter never wraps back to zero.
    function automatic logic [15:0] inc_sat(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // ---- Stage p0 -> sinc: two-flop synchronizer ----------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_p0 <= 4'd0;
            sinc    <= 4'd0;
        end else begin
            sinc_p0 <= botoes;
            sinc    <= sinc_p0;
        end
    end

    // ---- Debounce / decision FSM with registered outputs --------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            capturado    <= 4'd0;
            contador     <= 16'd0;
            jogada       <= 4'd0;
            jogada_feita <= 1'b0;
            invalida     <= 1'b0;
            tem_jogada   <= 1'b0;
        end else begin
            jogada_feita <= 1'b0;
            invalida     <= 1'b0;

            case (estado)
                OCIOSO: begin
                    if (sinc != 4'd0) begin
                        capturado <= sinc;
                        contador  <= 16'd0;
                        estado    <= FILTRANDO;
                    end
                end

                FILTRANDO: begin
                    if (sinc == 4'd0) begin
                        estado <= OCIOSO;
                    end else if (sinc != capturado) begin
                        // Pattern changed while bouncing: restart the run.
                        capturado <= sinc;
                        contador  <= 16'd0;
                    end else if (contador >= ALVO) begin
                        // habilita matters only on this edge.
                        tem_jogada <= 1'b1;
                        if (um_quente(capturado) && habilita) begin
                            estado       <= ACEITA;
                            jogada       <= capturado;
                            jogada_feita <= 1'b1;
                        end else begin
                            estado   <= REJEITA;
                            invalida <= multiplos(capturado);
                        end
                    end else begin
                        contador <= inc_sat(contador);
                    end
                end

                ACEITA, REJEITA: begin
                    estado <= ESPERA_SOLTAR;
                end

                ESPERA_SOLTAR: begin
                    // Extra buttons while held are ignored; only all-zero matters.
                    if (sinc == 4'd0) begin
                        estado     <= FILTRA_SOLTAR;
                        contador   <= 16'd0;
                        tem_jogada <= 1'b0;
                    end
                end

                FILTRA_SOLTAR: begin
                    if (sinc != 4'd0) begin
                        estado     <= ESPERA_SOLTAR;
                        tem_jogada <= 1'b1;
                    end else if (contador >= ALVO) begin
                        estado <= OCIOSO;
                    end else begin
                        contador <= inc_sat(contador);
                    end
                end

                default: begin
                    estado     <= OCIOSO;
                    tem_jogada <= 1'b0;
                end
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

    localparam int N = 4;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] botoes   = 4'd0;
    logic       habilita = 1'b0;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       invalida;
    logic       tem_jogada;
    logic [2:0] db_estado;

    condicionador_botoes #(.DEBOUNCE_CICLOS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .habilita     (habilita),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .invalida     (invalida),
        .tem_jogada   (tem_jogada),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: run-length view of the synchronized samples.
    // mode 0: waiting for N+1 identical nonzero samples (press)
    // mode 1: the one cycle after a decision
    // mode 2: waiting for N+1 consecutive zero samples (release)
    logic [3:0] m_s1, m_sinc, m_val, m_jog;
    logic       m_jf, m_inv, m_acc;
    int         mode, run, zrun;

    int jf_cnt, inv_cnt, first_jf, tick_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'd0; m_sinc = 4'd0; m_val = 4'd0; m_jog = 4'd0;
        m_jf = 1'b0; m_inv = 1'b0; m_acc = 1'b0;
        mode = 0; run = 0; zrun = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        if (!reset) begin
            model_reset();
            return;
        end
        s      = m_sinc;
        m_sinc = m_s1;
        m_s1   = botoes;
        m_jf   = 1'b0;
        m_inv  = 1'b0;
        case (mode)
            0: begin
                if (s == 4'd0) run = 0;
                else if (run > 0 && s == m_val) run++;
                else begin m_val = s; run = 1; end
                if (run == N + 1) begin
                    m_acc = ($countones(m_val) == 1) && habilita;
                    if (m_acc) begin m_jf = 1'b1; m_jog = m_val; end
                    else if ($countones(m_val) >= 2) m_inv = 1'b1;
                    mode = 1;
                    run  = 0;
                end
            end
            1: begin
                mode = 2;
                zrun = 0;
            end
            default: begin
                if (s == 4'd0) zrun++;
                else zrun = 0;
                if (zrun == N + 1) begin
                    mode = 0;
                    run  = 0;
                end
            end
        endcase
    endtask

    function automatic logic [2:0] exp_state();
        case (mode)
            0:       return (run == 0) ? 3'd0 : 3'd1;
            1:       return m_acc ? 3'd2 : 3'd3;
            default: return (zrun == 0) ? 3'd4 : 3'd5;
        endcase
    endfunction

    function automatic logic exp_tem();
        return (mode == 1) || (mode == 2 && zrun == 0);
    endfunction

    task automatic check_all();
        chk("jogada",       32'(jogada),       32'(m_jog));
        chk("jogada_feita", 32'(jogada_feita), 32'(m_jf));
        chk("invalida",     32'(invalida),     32'(m_inv));
        chk("tem_jogada",   32'(tem_jogada),   32'(exp_tem()));
        chk("db_estado",    32'(db_estado),    32'(exp_state()));
        chk("exclusive",    32'(jogada_feita & invalida), 32'd0);
    endtask

    task automatic clear_stats();
        jf_cnt = 0; inv_cnt = 0; first_jf = -1; tick_idx = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        tick_idx++;
        if (jogada_feita === 1'b1) begin
            jf_cnt++;
            if (first_jf < 0) first_jf = tick_idx;
        end
        if (invalida === 1'b1) inv_cnt++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called 1 time unit after an edge: reset falls and rises between edges.
    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_jogada", 32'(jogada), 32'd0);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [3:0] pat;
        int         r, len;

        model_reset();
        clear_stats();

        // Reset state, before any clock edge and across edges.
        #3;
        check_all();
        chk("rst_estado", 32'(db_estado), 32'd0);
        run_n(2);
        #5 reset = 1'b1;
        run_n(3);
        chk("idle_estado", 32'(db_estado), 32'd0);
        chk("idle_tem", 32'(tem_jogada), 32'd0);

        // Clean one-hot press.
        habilita = 1'b1;
        botoes   = 4'b0010;
        clear_stats();
        run_n(20);
        chk("p1_pulses",  32'(jf_cnt),   32'd1);
        chk("p1_latency", 32'(first_jf), 32'(N + 3));
        chk("p1_jogada",  32'(jogada),   32'b0010);
        chk("p1_tem",     32'(tem_jogada), 32'd1);
        botoes = 4'd0;
        run_n(14);
        chk("p1_released", 32'(tem_jogada), 32'd0);

        // Bouncing press, then stable hold.
        clear_stats();
        for (int i = 0; i < 6; i++) begin
            botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            run_n(2);
        end
        chk("bounce_none", 32'(jf_cnt + inv_cnt), 32'd0);
        botoes = 4'b0100;
        clear_stats();
        run_n(20);
        chk("bounce_pulse",  32'(jf_cnt), 32'd1);
        chk("bounce_jogada", 32'(jogada), 32'b0100);
        botoes = 4'd0;
        run_n(14);

        // Multi-button press.
        clear_stats();
        botoes = 4'b1001;
        run_n(20);
        chk("multi_inv",    32'(inv_cnt), 32'd1);
        chk("multi_jf",     32'(jf_cnt),  32'd0);
        chk("multi_jogada", 32'(jogada),  32'b0100);
        botoes = 4'd0;
        run_n(14);

        // One-hot with habilita=0 is discarded, then accepted on re-press.
        clear_stats();
        habilita = 1'b0;
        botoes   = 4'b1000;
        run_n(20);
        chk("dis_pulses", 32'(jf_cnt + inv_cnt), 32'd0);
        botoes = 4'd0;
        run_n(14);
        habilita = 1'b1;
        clear_stats();
        botoes = 4'b1000;
        run_n(20);
        chk("re_pulse",  32'(jf_cnt), 32'd1);
        chk("re_jogada", 32'(jogada), 32'b1000);
        botoes = 4'd0;
        run_n(14);

        // Reset during filtering with the button still held.
        botoes = 4'b0001;
        run_n(4);
        chk("mid_filtrando", 32'(db_estado), 32'd1);
        async_reset_pulse();
        clear_stats();
        run_n(14);
        chk("rst_pulse",   32'(jf_cnt),   32'd1);
        chk("rst_latency", 32'(first_jf), 32'(N + 3));
        chk("rst_jogada2", 32'(jogada),   32'b0001);
        botoes = 4'd0;
        run_n(14);

        // Randomized bouncing patterns against the model.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      pat = 4'(1 << $urandom_range(0, 3));
            else if (r < 6) pat = 4'd0;
            else            pat = 4'($urandom_range(0, 15));
            botoes = pat;
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                habilita = 1'($urandom_range(0, 1));
                tick();
            end
            if ($urandom_range(0, 59) == 0) async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_botoes.md
CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The module SHALL have one parameter: DEBOUNCE_CICLOS, default 500, number of consecutive stable synchronized samples required (10 ms at 50 kHz); legal range 2..65535.
REQ-002 The module SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port botoes, input, 4 bits: raw, asynchronous, bouncing push-button levels; 1 means pressed.
REQ-005 The module SHALL have port habilita, input, 1 bit: the downstream game FSM accepts a move.
REQ-006 The module SHALL have port jogada, output, 4 bits: registered one-hot code of the last accepted move.
REQ-007 The module SHALL have port jogada_feita, output, 1 bit: single-cycle pulse marking an accepted move.
REQ-008 The module SHALL have port invalida, output, 1 bit: single-cycle pulse marking a rejected multi-button press.
REQ-009 The module SHALL have port tem_jogada, output, 1 bit: level, high while a debounced nonzero pattern is held.
REQ-010 The module SHALL have port db_estado, output, 3 bits: current FSM state code, for debug display.

Function
REQ-011 The module SHALL pass botoes through a 2-flip-flop synchronizer per bit; only the second stage (sinc) is used downstream.
REQ-012 The FSM SHALL have states OCIOSO=0, FILTRANDO=1, ACEITA=2, REJEITA=3, ESPERA_SOLTAR=4, FILTRA_SOLTAR=5; other codes SHALL go to OCIOSO.
REQ-013 In OCIOSO, sinc nonzero SHALL capture sinc into an internal register, clear the 16-bit stability counter and go to FILTRANDO.
REQ-014 In FILTRANDO, sinc equal to the captured value SHALL increment the counter.
REQ-015 In FILTRANDO, sinc nonzero but different from the captured value SHALL recapture sinc and clear the counter.
REQ-016 In FILTRANDO, sinc zero SHALL return to OCIOSO with no output pulse.
REQ-017 When the counter reaches DEBOUNCE_CICLOS-1 with sinc still equal to the captured value, the FSM SHALL go to ACEITA if the captured value is one-hot and habilita=1, else to REJEITA.
REQ-018 ACEITA SHALL last exactly one cycle, assert jogada_feita, and load jogada with the captured value on the same edge.
REQ-019 REJEITA SHALL last exactly one cycle and assert invalida only if the captured value has two or more bits set; a one-hot press with habilita=0 SHALL be silently discarded.
REQ-020 ACEITA and REJEITA SHALL go to ESPERA_SOLTAR.
REQ-021 ESPERA_SOLTAR SHALL go to FILTRA_SOLTAR with the counter cleared when sinc becomes zero; extra buttons pressed while held SHALL be ignored.
REQ-022 FILTRA_SOLTAR SHALL count consecutive zero samples, return to ESPERA_SOLTAR on any nonzero sample, and reach OCIOSO after DEBOUNCE_CICLOS zero samples.
REQ-023 tem_jogada SHALL be 1 exactly in ACEITA, REJEITA and ESPERA_SOLTAR.
REQ-024 Latency: for a clean one-hot press with habilita=1, jogada_feita SHALL be high in the cycle following rising edge DEBOUNCE_CICLOS+3 counted from the first edge that samples the new botoes value.
REQ-025 At most one jogada_feita or invalida pulse SHALL occur per press-release cycle; the two SHALL never be high together.
REQ-026 habilita SHALL be sampled only on the FILTRANDO decision edge; changes at any other time SHALL have no effect.
REQ-027 jogada SHALL hold its value until the next ACEITA.
REQ-028 The counter SHALL saturate and never wrap.

Reset
REQ-029 While reset=0, all outputs, synchronizer flops, captured value and counter SHALL be 0, with the FSM in OCIOSO, independent of clock.
REQ-030 Reset asserted mid-press SHALL discard the press; after release of reset, a still-held button SHALL be treated as a new press from OCIOSO.

Verification (DEBOUNCE_CICLOS=4)
REQ-031 reset=0 then release, botoes=0 -> all outputs 0, db_estado=0.
REQ-032 botoes=0010 held 20 cycles, habilita=1 -> one jogada_feita pulse 7 edges after the change; jogada=0010; tem_jogada high until release is filtered.
REQ-033 botoes toggles 0100/0000 every 2 cycles for 12 cycles, then holds 0100 -> no pulse during toggling, one pulse after the hold is stable.
REQ-034 botoes=1001 held -> one invalida pulse, no jogada_feita, jogada unchanged.
REQ-035 botoes=1000 held with habilita=0 -> no pulse; release then re-press with habilita=1 -> jogada_feita, jogada=1000.
REQ-036 reset=0 during FILTRANDO while botoes=0001 stays held -> outputs cleared at once; after reset=1, a pulse occurs after full latency.
